bk_operand_sequencer: RTL

BK_OPERAND_SEQUENCER -- requirements
Module: bk_operand_sequencer

---
 rtl/bk_pkg.sv | 13 +
 rtl/bk_operand_sequencer_if.sv | 35 +++
 rtl/btn_debounce.sv | 59 +++++
 rtl/bk_operand_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared definitions for the operand sequencer: the default operand width
// and the sequencer FSM state encodings (also driven out on the status LEDs).
package bk_pkg;

    localparam int unsigned OPERAND_WIDTH = 8;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        PRESENT = 2'd2
    } state_e;

endpackage

// File: rtl/bk_operand_sequencer_if.sv
// Operand hand-off bus between the sequencer and the adder.
//   op_a, op_b  operand pair
//   op_cin      carry-in
//   op_valid    operand set complete and stable
//   op_ready    downstream has taken the operand set
// master: sequencer side, slave: adder side.
interface bk_operand_sequencer_if
    import bk_pkg::*;
#(
    parameter int unsigned WIDTH = OPERAND_WIDTH
) ();

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_valid;
    logic             op_ready;

    modport master (
        output op_a,
        output op_b,
        output op_cin,
        output op_valid,
        input  op_ready
    );

    modport slave (
        input  op_a,
        input  op_b,
        input  op_cin,
        input  op_valid,
        output op_ready
    );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, level debouncer and a
// one-cycle press pulse on each accepted 0->1 transition.
//   clk, rst   clock, synchronous active-high reset
//   btn_raw    raw asynchronous button level
//   pulse      registered one-cycle press pulse
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronized level disagrees with the
    // accepted level; accept it once it has disagreed for the full window.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/bk_operand_sequencer.sv
// Collects two operands and a carry-in from switches using a debounced load
// button, presents them to the adder with a valid/ready handshake, and
// supports a debounced clear button.
//   clk, rst    clock, synchronous active-high reset
//   sw          operand switches
//   cin_sw      carry-in switch, captured with operand B
//   btn_load    raw load button
//   btn_clear   raw clear button
//   state       current FSM state for the status LEDs
//   bus         operand hand-off bus (master side)
module bk_operand_sequencer
    import bk_pkg::*;
#(
    parameter int unsigned WIDTH           = OPERAND_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      sw,
    input  logic                  cin_sw,
    input  logic                  btn_load,
    input  logic                  btn_clear,
    output logic [1:0]            state,
    bk_operand_sequencer_if.master bus
);

    logic load_pulse;
    logic clear_pulse;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_cin_q, op_cin_d;
    logic             op_valid_q, op_valid_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_load),
        .pulse   (load_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clear),
        .pulse   (clear_pulse)
    );

    // Sequencer next state; clear dominates load and the handshake.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        op_valid_d = op_valid_q;
        if (clear_pulse) begin
            state_d    = WAIT_A;
            op_a_d     = '0;
            op_b_d     = '0;
            op_cin_d   = 1'b0;
            op_valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (load_pulse) begin
                        op_a_d  = sw;
                        state_d = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_pulse) begin
                        op_b_d     = sw;
                        op_cin_d   = cin_sw;
                        op_valid_d = 1'b1;
                        state_d    = PRESENT;
                    end
                end
                PRESENT: begin
                    if (op_valid_q && bus.op_ready) begin
                        op_valid_d = 1'b0;
                        state_d    = WAIT_A;
                    end
                end
                default: begin
                    // Unused encoding: fall back to a clean idle state.
                    op_valid_d = 1'b0;
                    state_d    = WAIT_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            op_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign state        = state_q;
    assign bus.op_a     = op_a_q;
    assign bus.op_b     = op_b_q;
    assign bus.op_cin   = op_cin_q;
    assign bus.op_valid = op_valid_q;

endmodule
